// File: rtl/elc_timer.sv
// ============================================================================
// elc_timer : dual-channel prescaled delay timer (short/long lockout)
// Revision  : 1.0
// ============================================================================
`default_nettype none

module elc_timer #(
    parameter int PRESCALE    = 1000,
    parameter int SHORT_TICKS = 5,
    parameter int LONG_TICKS  = 30,
    parameter int CW          = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          trS,
    input  logic          trL,
    input  logic          abort,
    output logic          tS,
    output logic          tL,
    output logic          busyS,
    output logic          busyL,
    output logic [CW-1:0] remaining
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    logic [1:0]    trig;
    logic [1:0]    busy;
    logic [1:0]    expire;
    logic [CW-1:0] cnt [2];

    assign trig = {trL, trS};

    // Channel 0 is the short lockout, channel 1 the long lockout.
    for (genvar i = 0; i < 2; i++) begin : g_ch
        localparam int TICKS = (i == 0) ? SHORT_TICKS : LONG_TICKS;
        localparam logic [CW-1:0] CNT_LOAD = CW'(TICKS);

        state_t        state_q, state_d;
        logic [PW-1:0] pre_q, pre_d;
        logic [CW-1:0] cnt_q, cnt_d;

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= ST_IDLE;
                pre_q   <= '0;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                pre_q   <= pre_d;
                cnt_q   <= cnt_d;
            end
        end

        always_comb begin
            state_d = state_q;
            pre_d   = pre_q;
            cnt_d   = cnt_q;
            if (abort) begin
                state_d = ST_IDLE;
                pre_d   = '0;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (trig[i]) begin
                            state_d = ST_RUN;
                            pre_d   = '0;
                            cnt_d   = CNT_LOAD;
                        end
                    end
                    ST_RUN: begin
                        if (trig[i]) begin
                            pre_d = '0;
                            cnt_d = CNT_LOAD;
                        end else if (pre_q == PRE_LAST) begin
                            pre_d = '0;
                            cnt_d = cnt_q - CW'(1);
                            if (cnt_q == CW'(1)) begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            pre_d = pre_q + PW'(1);
                        end
                    end
                    ST_DONE: begin
                        // Counters are already zero here; a trigger restarts at once.
                        if (trig[i]) begin
                            state_d = ST_RUN;
                            pre_d   = '0;
                            cnt_d   = CNT_LOAD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        pre_d   = '0;
                        cnt_d   = '0;
                    end
                endcase
            end
        end

        assign busy[i]   = (state_q == ST_RUN);
        assign expire[i] = (state_q == ST_DONE);
        assign cnt[i]    = cnt_q;
    end

    assign tS    = expire[0];
    assign tL    = expire[1];
    assign busyS = busy[0];
    assign busyL = busy[1];

    // The long channel has display priority.
    assign remaining = busy[1] ? cnt[1] :
                       busy[0] ? cnt[0] : '0;

endmodule

`default_nettype wire
